sram_in_feeder: RTL and testbench

//  Read controller and skew stage between input SRAM (sram_128x32_in) and west edge of systolic array.

---
 rtl/tpu_feed_pkg.sv | 25 ++
 rtl/feed_skew_line.sv | 39 +++
 rtl/sram_in_feeder.sv | 187 ++++++++++++++++++
 tb/tb_sram_in_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_feed_pkg.sv
// Shared constants and types for the input-SRAM feeder that drives the west edge of the systolic array.
package tpu_feed_pkg;

    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned ROW_W      = LANES * LANE_W;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DRAIN_W    = (LANES > 2) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

    // One SRAM word: the spare bit marks the row as real data rather than padding.
    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] ops;
    } sram_word_t;

endpackage

// File: rtl/feed_skew_line.sv
// Triangular delay line: lane l is held l+1 stages so rows enter the array diagonally.
module feed_skew_line
    import tpu_feed_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstb_i,
    input  logic             en_i,
    input  logic [ROW_W-1:0] row_data_i,
    input  logic [LANES-1:0] row_valid_i,
    output logic [ROW_W-1:0] a_data_o,
    output logic [LANES-1:0] a_valid_o
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W:0]         in_c;
        logic [l:0][LANE_W:0]    pipe_q;
        logic [l:0][LANE_W:0]    pipe_d;

        assign in_c = {row_valid_i[l], row_data_i[l*LANE_W +: LANE_W]};

        if (l == 0) begin : g_first
            assign pipe_d = in_c;
        end else begin : g_rest
            assign pipe_d = {pipe_q[l-1:0], in_c};
        end

        always_ff @(posedge clk_i) begin
            if (!rstb_i) begin
                pipe_q <= '0;
            end else if (en_i) begin
                pipe_q <= pipe_d;
            end
        end

        assign a_data_o[l*LANE_W +: LANE_W] = pipe_q[l][LANE_W-1:0];
        assign a_valid_o[l]                 = pipe_q[l][LANE_W];
    end

endmodule

// File: rtl/sram_in_feeder.sv
// Streams a block of words out of the input SRAM, buffers them against read latency and
// hands each word to the skew line as one row of per-lane operands.
module sram_in_feeder
    import tpu_feed_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned DATA_WIDTH = 33
)
(
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic                  en,
    output logic                  busy,
    output logic                  done,
    output logic                  csb0,
    output logic                  web0,
    output logic                  spare_wen0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic [ROW_W-1:0]      a_data,
    output logic [LANES-1:0]      a_valid
);

    feed_state_e           state_q, state_d;
    logic                  csb0_q, csb0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] issue_left_q, issue_left_d;
    logic [ADDR_WIDTH-1:0] pop_left_q, pop_left_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    sram_word_t            fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

    logic                  push_c;
    logic                  pop_c;
    sram_word_t            head_c;
    logic                  row_valid_c;
    logic [ROW_W-1:0]      row_data_c;
    logic [ADDR_WIDTH-1:0] start_addr_c;

    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign start_addr_c = ADDR_WIDTH'(32'(base_addr) % DEPTH);

    // SRAM data is only valid at the edge right after its request edge, so push exactly then.
    assign push_c     = inflight_q;
    assign pop_c      = (state_q == ST_RUN) && en && (fifo_cnt_q != '0);
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    assign inflight_d = !csb0_q;

    assign head_c      = fifo_mem_q[rd_ptr_q];
    assign row_valid_c = pop_c && head_c.valid;
    assign row_data_c  = row_valid_c ? head_c.ops : '0;

    always_comb begin
        state_d      = state_q;
        csb0_d       = 1'b1;
        addr0_d      = addr0_q;
        next_addr_d  = next_addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        drain_cnt_d  = drain_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_RUN;
                        csb0_d       = 1'b0;
                        addr0_d      = start_addr_c;
                        next_addr_d  = wrap_inc(start_addr_c);
                        issue_left_d = num_words - ADDR_WIDTH'(1);
                        pop_left_d   = num_words;
                    end
                end
            end
            ST_RUN: begin
                // Credit: FIFO occupancy plus reads still in the SRAM must never exceed the FIFO.
                if ((issue_left_q != '0) &&
                    ((CNT_W+1)'(fifo_cnt_d) + (CNT_W+1)'(inflight_d) < (CNT_W+1)'(FIFO_DEPTH))) begin
                    csb0_d       = 1'b0;
                    addr0_d      = next_addr_q;
                    next_addr_d  = wrap_inc(next_addr_q);
                    issue_left_d = issue_left_q - ADDR_WIDTH'(1);
                end
                if (pop_c) begin
                    pop_left_d = pop_left_q - ADDR_WIDTH'(1);
                    if (pop_left_q == ADDR_WIDTH'(1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    if (drain_cnt_q == DRAIN_W'(LANES - 2)) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state_q      <= ST_IDLE;
            csb0_q       <= 1'b1;
            addr0_q      <= '0;
            next_addr_q  <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            drain_cnt_q  <= '0;
            inflight_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            csb0_q       <= csb0_d;
            addr0_q      <= addr0_d;
            next_addr_q  <= next_addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            drain_cnt_q  <= drain_cnt_d;
            inflight_q   <= inflight_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fifo_cnt_q   <= fifo_cnt_d;
            if (push_c) begin
                fifo_mem_q[wr_ptr_q] <= sram_word_t'(dout0);
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    feed_skew_line u_skew (
        .clk_i       (clk0),
        .rstb_i      (rstb0),
        .en_i        (en),
        .row_data_i  (row_data_c),
        .row_valid_i ({LANES{row_valid_c}}),
        .a_data_o    (a_data),
        .a_valid_o   (a_valid)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign csb0       = csb0_q;
    assign addr0      = addr0_q;
    assign web0       = 1'b1;
    assign spare_wen0 = 1'b0;
    assign din0       = '0;

endmodule

// File: tb/tb_sram_in_feeder.sv
// Bench for sram_in_feeder with a behavioural 128x33 SRAM whose read data is only valid for one edge.
module tb_sram_in_feeder;

    logic        clk0 = 1'b0;
    logic        rstb0;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_words;
    logic        en;
    logic        busy;
    logic        done;
    logic        csb0;
    logic        web0;
    logic        spare_wen0;
    logic [7:0]  addr0;
    logic [32:0] din0;
    logic [32:0] dout0;
    logic [31:0] a_data;
    logic [3:0]  a_valid;

    localparam logic [32:0] POISON = 33'h1_DEAD_BEEF;

    logic [32:0] mem [128];
    logic [7:0]  lane_q [4][$];
    int          tq [4][$];
    logic [7:0]  addr_q [$];

    int   total = 0;
    int   bad = 0;
    int   reads_cnt = 0;
    int   l0cnt = 0;
    int   tick = 0;
    int   ahead_base = 0;
    bit   adv = 1'b0;
    bit   mon_en = 1'b0;
    bit   model_en = 1'b0;
    bit   ahead_en = 1'b0;
    bit   rd_req = 1'b0;
    logic [7:0]  rd_a = '0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_valid = '0;

    always #5 clk0 = ~clk0;

    sram_in_feeder dut (
        .clk0       (clk0),
        .rstb0      (rstb0),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .csb0       (csb0),
        .web0       (web0),
        .spare_wen0 (spare_wen0),
        .addr0      (addr0),
        .din0       (din0),
        .dout0      (dout0),
        .a_data     (a_data),
        .a_valid    (a_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SRAM model: data appears shortly after the request edge and is poisoned after the next edge.
    always @(posedge clk0) begin
        if (model_en && !csb0) begin
            reads_cnt++;
            if (addr_q.size() == 0) begin
                check("rd_extra", 64'(addr0), 64'hFFFF);
            end else begin
                check("rd_addr", 64'(addr0), 64'(addr_q.pop_front()));
            end
            rd_req = 1'b1;
            rd_a   = addr0;
        end else begin
            rd_req = 1'b0;
        end
        #1;
        dout0 = rd_req ? mem[rd_a[6:0]] : POISON;
    end

    always @(posedge clk0) begin
        adv = en || !rstb0;
        if (en && rstb0) tick++;
    end

    // Output monitor: scoreboard pops on advancing cycles, hold check on stalled ones.
    always @(negedge clk0) begin
        if (mon_en) begin
            if (adv) begin
                for (int i = 0; i < 4; i++) begin
                    if (a_valid[i]) begin
                        if (lane_q[i].size() == 0) begin
                            check($sformatf("lane%0d_extra", i), 64'(a_data[i*8 +: 8]), 64'hFFFF);
                        end else begin
                            check($sformatf("lane%0d_data", i), 64'(a_data[i*8 +: 8]),
                                  64'(lane_q[i].pop_front()));
                        end
                        if (i == 0) begin
                            l0cnt++;
                            for (int j = 1; j < 4; j++) tq[j].push_back(tick);
                        end else if (tq[i].size() != 0) begin
                            check($sformatf("lane%0d_skew", i), 64'(tick), 64'(tq[i].pop_front() + i));
                        end
                    end else begin
                        check($sformatf("lane%0d_zero", i), 64'(a_data[i*8 +: 8]), 64'd0);
                    end
                end
            end else begin
                check("hold_data", 64'(a_data), 64'(prev_data));
                check("hold_valid", 64'(a_valid), 64'(prev_valid));
            end
            if (ahead_en) check("ahead", 64'((reads_cnt - l0cnt - ahead_base) <= 2), 64'd1);
        end
        prev_data  = a_data;
        prev_valid = a_valid;
    end

    task automatic start_job(input logic [7:0] b, input logic [7:0] n);
        logic [32:0] w;
        logic [7:0]  a;
        for (int k = 0; k < int'(n); k++) begin
            a = 8'((int'(b) + k) % 128);
            addr_q.push_back(a);
            w = mem[a[6:0]];
            if (w[32]) begin
                for (int i = 0; i < 4; i++) lane_q[i].push_back(w[i*8 +: 8]);
            end
        end
        ahead_base = reads_cnt - l0cnt;
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        @(posedge clk0);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int stall_at, input int stall_len, input int ign_at,
                             input int n, input int r0);
        int cyc;
        int seen;
        cyc  = 0;
        seen = 0;
        while (seen == 0 && cyc < 300) begin
            en    = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start = (cyc == ign_at);
            if (cyc == ign_at) begin
                base_addr = 8'd100;
                num_words = 8'd2;
            end
            @(posedge clk0);
            #1;
            cyc++;
            if (done) seen = 1;
        end
        start = 1'b0;
        en    = 1'b1;
        check("done_seen", 64'(seen), 64'd1);
        check("reads", 64'(reads_cnt - r0), 64'(n));
        @(posedge clk0);
        #1;
        check("done_pulse", 64'(done), 64'd0);
        check("busy_end", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) check($sformatf("lane%0d_left", i), 64'(lane_q[i].size()), 64'd0);
        check("addr_left", 64'(addr_q.size()), 64'd0);
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 128; i++) mem[i] = {1'b1, 32'($urandom)};
        mem[5]  = 33'h1_04030201;
        mem[6]  = 33'h1_08070605;
        mem[7]  = 33'h1_0C0B0A09;
        mem[40] = 33'h0_55667788;
        dout0     = POISON;
        rstb0     = 1'b0;
        start     = 1'b0;
        en        = 1'b1;
        base_addr = '0;
        num_words = '0;
        repeat (3) @(posedge clk0);
        #1;
        check("rst_csb0", 64'(csb0), 64'd1);
        check("rst_addr0", 64'(addr0), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_adata", 64'(a_data), 64'd0);
        check("rst_avalid", 64'(a_valid), 64'd0);
        check("web0", 64'(web0), 64'd1);
        check("spare_wen0", 64'(spare_wen0), 64'd0);
        check("din0", 64'(din0), 64'd0);
        rstb0    = 1'b1;
        model_en = 1'b1;
        mon_en   = 1'b1;
        repeat (2) @(posedge clk0);
        #1;

        // Basic stream with first-word latency
        r0 = reads_cnt;
        start_job(8'd5, 8'd3);
        check("b_busy", 64'(busy), 64'd1);
        check("b_csb0_e0", 64'(csb0), 64'd0);
        check("b_addr_e0", 64'(addr0), 64'd5);
        @(posedge clk0); #1;
        check("b_addr_e1", 64'(addr0), 64'd6);
        @(posedge clk0); #1;
        check("b_l0_e2", 64'(a_valid[0]), 64'd0);
        @(posedge clk0); #1;
        check("b_l0_e3", 64'(a_valid[0]), 64'd1);
        check("b_l0_data_e3", 64'(a_data[7:0]), 64'h01);
        wait_done(-1, 0, -1, 3, r0);

        // Address wrap
        r0 = reads_cnt;
        start_job(8'd126, 8'd4);
        wait_done(-1, 0, -1, 4, r0);

        // Stall mid-stream plus an ignored start
        r0 = reads_cnt;
        ahead_en = 1'b1;
        start_job(8'd20, 8'd8);
        wait_done(3, 5, 1, 8, r0);
        ahead_en = 1'b0;

        // Padding row in the middle of the block
        r0 = reads_cnt;
        start_job(8'd38, 8'd5);
        wait_done(-1, 0, -1, 5, r0);

        // Zero-length job
        r0 = reads_cnt;
        start_job(8'd10, 8'd0);
        check("z_done", 64'(done), 64'd1);
        check("z_csb0", 64'(csb0), 64'd1);
        @(posedge clk0); #1;
        check("z_done_off", 64'(done), 64'd0);
        check("z_busy_off", 64'(busy), 64'd0);
        check("z_csb0_2", 64'(csb0), 64'd1);
        check("z_reads", 64'(reads_cnt - r0), 64'd0);

        // Reset in the middle of a run, then a clean job
        start_job(8'd60, 8'd6);
        repeat (3) @(posedge clk0);
        #1;
        rstb0 = 1'b0;
        @(posedge clk0); #1;
        check("mr_csb0", 64'(csb0), 64'd1);
        check("mr_addr0", 64'(addr0), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_done", 64'(done), 64'd0);
        check("mr_adata", 64'(a_data), 64'd0);
        check("mr_avalid", 64'(a_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            lane_q[i].delete();
            tq[i].delete();
        end
        addr_q.delete();
        rstb0 = 1'b1;
        repeat (2) @(posedge clk0);
        #1;
        r0 = reads_cnt;
        start_job(8'd70, 8'd3);
        wait_done(-1, 0, -1, 3, r0);

        repeat (4) @(posedge clk0);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
